// File: rtl/ttl_out_pkg.sv
// Shared sizing, mode and pulse-state definitions for the TTL output driver.
package ttl_out_pkg;

  localparam int NUM_CH = 8;
  localparam int PW_W   = 16;
  localparam int TS_W   = 64;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_PULSE = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/ttl_out_driver_if.sv
// Event strobe and event word from the upstream output buffer.
interface ttl_out_driver_if #(
  parameter int NUM_CH = ttl_out_pkg::NUM_CH
);

  logic                                counter_matched;
  logic [ttl_out_pkg::TS_W+NUM_CH-1:0] rto_out;

  modport master (output counter_matched, output rto_out);
  modport slave  (input  counter_matched, input  rto_out);

endinterface

// File: rtl/ttl_pulse_channel.sv
// One TTL channel: level hold register plus pulse FSM and remaining-cycle counter.
//
// state  | meaning
// IDLE   | no pulse running; pulse-mode output is low
// ACTIVE | pulse running; cnt_q holds cycles left after the current one
module ttl_pulse_channel #(
  parameter int PW_W = ttl_out_pkg::PW_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            evt,
  input  logic            data,
  input  logic            mode_bit,
  input  logic [PW_W-1:0] pulse_width,
  output logic            level_next,
  output logic            busy,
  output logic            retrig
);

  import ttl_out_pkg::*;

  localparam logic [PW_W-1:0] ONE = PW_W'(1);

  mode_e           mode;
  pulse_state_e    state_q, state_d;
  logic [PW_W-1:0] cnt_q, cnt_d;
  logic [PW_W-1:0] width_m1;
  logic            lvl_q, lvl_d;
  logic            trig;

  assign mode     = mode_e'(mode_bit);
  // A zero width still produces a single-cycle pulse.
  assign width_m1 = (pulse_width == '0) ? '0 : (pulse_width - ONE);

  // Next-state, counter and level selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lvl_d      = lvl_q;
    retrig     = 1'b0;
    trig       = evt && data && (mode == MODE_PULSE);
    if (mode == MODE_LEVEL) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (evt) lvl_d = data;
    end else if (trig) begin
      state_d = ACTIVE;
      cnt_d   = width_m1;
      retrig  = (state_q == ACTIVE);
    end else if (state_q == ACTIVE) begin
      if (cnt_q == '0) state_d = IDLE;
      else             cnt_d   = cnt_q - ONE;
    end
    level_next = (mode == MODE_PULSE) ? (state_d == ACTIVE) : lvl_d;
  end

  // State, counter and held level registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
    end
  end

  assign busy = (state_q == ACTIVE);

endmodule

// File: rtl/ttl_out_driver.sv
// TTL output driver: per-channel level/pulse generation, override, polarity,
// event timestamp capture, saturating event counter and sticky overlap error.
module ttl_out_driver #(
  parameter int NUM_CH = ttl_out_pkg::NUM_CH,
  parameter int PW_W   = ttl_out_pkg::PW_W
) (
  input  logic              clk,
  input  logic              reset,
  ttl_out_driver_if.slave   evt_if,
  input  logic [NUM_CH-1:0] mode,
  input  logic [PW_W-1:0]   pulse_width,
  input  logic [NUM_CH-1:0] polarity,
  input  logic [NUM_CH-1:0] override_en,
  input  logic [NUM_CH-1:0] override_val,
  input  logic              err_clear,
  output logic [NUM_CH-1:0] ttl_out,
  output logic [NUM_CH-1:0] busy,
  output logic [63:0]       last_event_ts,
  output logic [31:0]       event_count,
  output logic              overlap_error
);

  logic [NUM_CH-1:0] level_next;
  logic [NUM_CH-1:0] retrig;

  logic [NUM_CH-1:0] ttl_out_q, ttl_out_d;
  logic [63:0]       last_event_ts_q, last_event_ts_d;
  logic [31:0]       event_count_q, event_count_d;
  logic              overlap_error_q, overlap_error_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ttl_pulse_channel #(.PW_W(PW_W)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .evt         (evt_if.counter_matched),
      .data        (evt_if.rto_out[i]),
      .mode_bit    (mode[i]),
      .pulse_width (pulse_width),
      .level_next  (level_next[i]),
      .busy        (busy[i]),
      .retrig      (retrig[i])
    );
  end

  // Output mux, timestamp capture, saturating count and sticky error.
  always_comb begin
    ttl_out_d       = ((override_en & override_val) | (~override_en & level_next)) ^ polarity;
    last_event_ts_d = last_event_ts_q;
    event_count_d   = event_count_q;
    overlap_error_d = overlap_error_q;
    if (evt_if.counter_matched) begin
      last_event_ts_d = evt_if.rto_out[NUM_CH+63:NUM_CH];
      if (event_count_q != 32'hFFFF_FFFF) event_count_d = event_count_q + 32'd1;
    end
    // A retrigger wins over a simultaneous clear.
    if (|retrig)        overlap_error_d = 1'b1;
    else if (err_clear) overlap_error_d = 1'b0;
  end

  // Output and status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ttl_out_q       <= '0;
      last_event_ts_q <= '0;
      event_count_q   <= '0;
      overlap_error_q <= 1'b0;
    end else begin
      ttl_out_q       <= ttl_out_d;
      last_event_ts_q <= last_event_ts_d;
      event_count_q   <= event_count_d;
      overlap_error_q <= overlap_error_d;
    end
  end

  assign ttl_out       = ttl_out_q;
  assign last_event_ts = last_event_ts_q;
  assign event_count   = event_count_q;
  assign overlap_error = overlap_error_q;

endmodule

// File: tb/tb_ttl_out_driver.sv
// Scoreboard bench for ttl_out_driver: stimulus queues cycle-tagged expectations,
// a monitor compares them at the negedge of the cycle they are due.
module tb_ttl_out_driver;

  localparam int K_TTL = 0, K_BUSY = 1, K_ERR = 2, K_CNT = 3, K_TS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  mode, polarity, override_en, override_val;
  logic [15:0] pulse_width;
  logic        err_clear;
  logic [7:0]  ttl_out, busy;
  logic [63:0] last_event_ts;
  logic [31:0] event_count;
  logic        overlap_error;

  ttl_out_driver_if #(.NUM_CH(8)) evt_if ();

  ttl_out_driver #(.NUM_CH(8), .PW_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .evt_if        (evt_if),
    .mode          (mode),
    .pulse_width   (pulse_width),
    .polarity      (polarity),
    .override_en   (override_en),
    .override_val  (override_val),
    .err_clear     (err_clear),
    .ttl_out       (ttl_out),
    .busy          (busy),
    .last_event_ts (last_event_ts),
    .event_count   (event_count),
    .overlap_error (overlap_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void expect_at(int c, int kind, logic [63:0] val, string name);
    exp_t e;
    e.cyc = c; e.kind = kind; e.val = val; e.name = name;
    sb.push_back(e);
  endfunction

  function automatic logic [63:0] actual(int kind);
    case (kind)
      K_TTL:   return {56'd0, ttl_out};
      K_BUSY:  return {56'd0, busy};
      K_ERR:   return {63'd0, overlap_error};
      K_CNT:   return {32'd0, event_count};
      default: return last_event_ts;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          checks++;
          if (actual(sb[i].kind) !== sb[i].val) begin
            errors++;
            $display("FAIL %s cyc %0d: got %h expected %h", sb[i].name, cyc,
                     actual(sb[i].kind), sb[i].val);
          end
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s cyc %0d: check never reached", sb[i].name, sb[i].cyc);
          sb.delete(i);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ev(logic [7:0] d, logic [63:0] ts);
    evt_if.counter_matched = 1'b1;
    evt_if.rto_out         = {ts, d};
    tick();
    evt_if.counter_matched = 1'b0;
  endtask

  int c;

  initial begin
    reset = 1'b0; mode = 8'h00; pulse_width = 16'd4; polarity = 8'hFF;
    override_en = 8'h00; override_val = 8'h00; err_clear = 1'b0;
    evt_if.counter_matched = 1'b0; evt_if.rto_out = '0;
    tick();

    // Reset holds everything at zero and ignores events.
    c = cyc;
    for (int k = 1; k <= 3; k++) begin
      expect_at(c + k, K_TTL, 0, "rst_ttl");
      expect_at(c + k, K_CNT, 0, "rst_cnt");
      expect_at(c + k, K_TS,  0, "rst_ts");
    end
    expect_at(c + 3, K_BUSY, 0, "rst_busy");
    expect_at(c + 3, K_ERR,  0, "rst_err");
    ev(8'hFF, 64'hDEAD); ev(8'hFF, 64'hDEAD); ev(8'hFF, 64'hDEAD);
    reset = 1'b1; polarity = 8'h00;
    c = cyc;
    expect_at(c + 1, K_TTL, 0, "rel_ttl");
    expect_at(c + 1, K_CNT, 0, "rel_cnt");
    tick(); tick();

    // Level mode.
    c = cyc;
    expect_at(c + 1, K_TTL, 8'hA5, "lvl_ttl");
    expect_at(c + 1, K_CNT, 1, "lvl_cnt");
    expect_at(c + 1, K_TS,  64'h1122_3344_5566_7788, "lvl_ts");
    expect_at(c + 3, K_TTL, 8'hA5, "lvl_hold");
    ev(8'hA5, 64'h1122_3344_5566_7788); tick(); tick();
    c = cyc;
    expect_at(c + 1, K_TTL, 8'h00, "lvl_clr");
    expect_at(c + 1, K_CNT, 2, "lvl_cnt2");
    ev(8'h00, 64'h10); tick();

    // Pulse of width 4; a zero data bit mid-pulse has no effect.
    mode = 8'h01; tick();
    c = cyc;
    for (int k = 1; k <= 4; k++) begin
      expect_at(c + k, K_TTL,  8'h01, "pw4_ttl");
      expect_at(c + k, K_BUSY, 8'h01, "pw4_busy");
    end
    expect_at(c + 5, K_TTL,  8'h00, "pw4_end");
    expect_at(c + 5, K_BUSY, 8'h00, "pw4_busy_end");
    expect_at(c + 5, K_ERR,  0, "pw4_err");
    expect_at(c + 5, K_CNT,  4, "pw4_cnt");
    expect_at(c + 3, K_TS,   64'h21, "pw4_ts");
    ev(8'h01, 64'h20); tick(); ev(8'h00, 64'h21); tick(); tick(); tick(); tick();

    // Retrigger extends pulse and sets the sticky error.
    c = cyc;
    for (int k = 1; k <= 6; k++) expect_at(c + k, K_TTL, 8'h01, "rt_ttl");
    expect_at(c + 7, K_TTL,  8'h00, "rt_end");
    expect_at(c + 6, K_BUSY, 8'h01, "rt_busy");
    expect_at(c + 7, K_BUSY, 8'h00, "rt_busy_end");
    expect_at(c + 2, K_ERR,  0, "rt_err_pre");
    expect_at(c + 3, K_ERR,  1, "rt_err_set");
    expect_at(c + 7, K_ERR,  1, "rt_err_sticky");
    expect_at(c + 7, K_CNT,  6, "rt_cnt");
    ev(8'h01, 64'h30); tick(); ev(8'h01, 64'h31); tick(); tick(); tick(); tick(); tick();
    c = cyc; err_clear = 1'b1;
    expect_at(c + 1, K_ERR, 0, "clr_err");
    tick(); err_clear = 1'b0;

    // Retrigger coinciding with err_clear keeps the error set.
    c = cyc;
    expect_at(c + 1, K_ERR, 0, "prec_pre");
    expect_at(c + 2, K_ERR, 1, "prec_set");
    expect_at(c + 3, K_ERR, 1, "prec_hold");
    ev(8'h01, 64'h40); err_clear = 1'b1; ev(8'h01, 64'h41); err_clear = 1'b0;
    repeat (6) tick();
    c = cyc; err_clear = 1'b1;
    expect_at(c + 1, K_ERR, 0, "clr_err2");
    tick(); err_clear = 1'b0;

    // Mode switch to level aborts a running pulse.
    c = cyc;
    expect_at(c + 1, K_TTL,  8'h01, "msw_on1");
    expect_at(c + 2, K_TTL,  8'h01, "msw_on2");
    expect_at(c + 3, K_TTL,  8'h00, "msw_off");
    expect_at(c + 3, K_BUSY, 8'h00, "msw_busy");
    expect_at(c + 3, K_CNT,  9, "msw_cnt");
    ev(8'h01, 64'h50); tick(); mode = 8'h00; tick();

    // Override and polarity.
    c = cyc; polarity = 8'hFF; override_en = 8'h0F; override_val = 8'h05;
    expect_at(c + 1, K_TTL,  8'hFA, "ovr_ttl");
    expect_at(c + 1, K_BUSY, 8'h00, "ovr_busy");
    tick();
    c = cyc; polarity = 8'h00; override_en = 8'h00; override_val = 8'h00;
    expect_at(c + 1, K_TTL, 8'h00, "ovr_off");
    tick();

    // Zero width gives a single-cycle pulse on channel 7.
    mode = 8'h80; pulse_width = 16'd0; tick();
    c = cyc;
    expect_at(c + 1, K_TTL,  8'h80, "pw0_on");
    expect_at(c + 1, K_BUSY, 8'h80, "pw0_busy");
    expect_at(c + 2, K_TTL,  8'h00, "pw0_off");
    expect_at(c + 2, K_BUSY, 8'h00, "pw0_busy_off");
    ev(8'h80, 64'h60); tick(); tick();

    // Reset mid-pulse aborts immediately.
    pulse_width = 16'd100;
    c = cyc;
    for (int k = 1; k <= 3; k++) expect_at(c + k, K_TTL, 8'h80, "mid_on");
    expect_at(c + 4, K_TTL,  8'h00, "mid_rst_ttl");
    expect_at(c + 4, K_BUSY, 8'h00, "mid_rst_busy");
    expect_at(c + 4, K_CNT,  0, "mid_rst_cnt");
    expect_at(c + 4, K_TS,   0, "mid_rst_ts");
    ev(8'h80, 64'h70); tick(); tick(); reset = 1'b0; tick(); tick();
    c = cyc; reset = 1'b1; polarity = 8'h3C; override_en = 8'h01; override_val = 8'h01;
    expect_at(c + 1, K_TTL,  8'h3D, "post_rst_ttl");
    expect_at(c + 1, K_BUSY, 8'h00, "post_rst_busy");
    tick();
    c = cyc; polarity = 8'h00; override_en = 8'h00; override_val = 8'h00;
    expect_at(c + 1, K_TTL,  8'h00, "post_rst_idle");
    expect_at(c + 1, K_BUSY, 8'h00, "post_rst_idle_busy");
    tick();

    // Event counter saturation.
    force dut.event_count_q = 32'hFFFF_FFFE;
    tick();
    release dut.event_count_q;
    c = cyc;
    expect_at(c + 1, K_CNT, 32'hFFFF_FFFE, "sat_preload");
    tick();
    c = cyc;
    for (int k = 1; k <= 3; k++) expect_at(c + k, K_CNT, 32'hFFFF_FFFF, "sat_cnt");
    expect_at(c + 3, K_TS, 64'h83, "sat_ts");
    ev(8'h00, 64'h81); ev(8'h00, 64'h82); ev(8'h00, 64'h83);
    tick();

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s cyc %0d: check never reached", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttl_out_driver.md
TTL_OUT_DRIVER -- requirements
Module: ttl_out_driver

Interface
REQ-001 Parameter NUM_CH, 8, number of TTL channels; width of the data byte carried in the event word.
REQ-002 Parameter PW_W, 16, width of the pulse-width configuration and per-channel pulse counters.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; asserted when 0, sampled on posedge clk.
REQ-005 counter_matched  input  1  one-cycle event strobe from the upstream output buffer.
REQ-006 rto_out  input  72  event word: [71:8] timestamp, [7:0] channel data; valid when counter_matched=1.
REQ-007 mode  input  NUM_CH  per-channel mode: 0=level, 1=pulse.
REQ-008 pulse_width  input  PW_W  pulse length in clk cycles, shared by all pulse-mode channels.
REQ-009 polarity  input  NUM_CH  per-channel output inversion: 1=invert.
REQ-010 override_en  input  NUM_CH  per-channel manual override enable.
REQ-011 override_val  input  NUM_CH  manual level used when override_en[i]=1.
REQ-012 err_clear  input  1  clears the sticky overlap error.
REQ-013 ttl_out  output  NUM_CH  registered TTL drive.
REQ-014 busy  output  NUM_CH  pulse in progress per channel.
REQ-015 last_event_ts  output  64  timestamp of the most recent accepted event.
REQ-016 event_count  output  32  number of accepted events, saturating.
REQ-017 overlap_error  output  1  sticky; set when a pulse is retriggered while still busy.

Function
REQ-018 An event is accepted in cycle N when counter_matched=1 in N; ttl_out SHALL reflect it in cycle N+1 (1-cycle latency).
REQ-019 Level channel i: internal level[i] SHALL load rto_out[i] on each accepted event and hold otherwise.
REQ-020 Pulse channel i with rto_out[i]=1: internal level[i] SHALL be high for exactly max(pulse_width,1) cycles, N+1 through N+W; pulse_width=0 is treated as 1.
REQ-021 Pulse channel i with rto_out[i]=0: no effect; any running pulse continues.
REQ-022 Retrigger while busy[i]=1: counter reloads (pulse extends to N+W from the new event), and overlap_error SHALL set in N+1.
REQ-023 Per-channel pulse FSM: IDLE -> ACTIVE on trigger; ACTIVE -> IDLE when the counter reaches its last cycle with no retrigger; ACTIVE -> ACTIVE on retrigger; busy[i]=1 exactly in ACTIVE.
REQ-024 A pulse_width change during ACTIVE SHALL NOT affect the running pulse; it applies from the next trigger.
REQ-025 A mode[i] change 1->0 SHALL force IDLE next cycle; the channel then outputs its held level (0 unless set by a level event).
REQ-026 ttl_out[i] = (override_en[i] ? override_val[i] : level[i]) XOR polarity[i], registered; overrides and polarity take effect with 1-cycle latency and do not disturb pulse counters.
REQ-027 event_count SHALL increment by 1 per accepted event and saturate at 32'hFFFF_FFFF.
REQ-028 last_event_ts SHALL load rto_out[71:8] on each accepted event.
REQ-029 err_clear=1 clears overlap_error next cycle; a simultaneous retrigger in the same cycle SHALL take precedence (error remains set).
REQ-030 The pulse counter SHALL be PW_W bits wide and SHALL NOT wrap; the maximum pulse is 2^PW_W-1 cycles.

Reset
REQ-031 While reset=0: ttl_out=0, busy=0, all channels IDLE, level=0, event_count=0, last_event_ts=0, overlap_error=0.
REQ-032 Reset mid-pulse SHALL abort the pulse immediately; the first cycle after release drives polarity^override per REQ-026 with level=0.
REQ-033 counter_matched asserted during reset SHALL be ignored.

Structure
REQ-034 Shared package ttl_out_pkg SHALL hold NUM_CH, PW_W, the per-channel mode enum (MODE_LEVEL, MODE_PULSE) and the pulse FSM state enum (IDLE, ACTIVE).
REQ-035 One sub-module, ttl_pulse_channel (one channel's FSM, counter and level), SHALL be instantiated NUM_CH times; counters, timestamp and error logic stay in the top.

Verification
REQ-036 mode=0x00, polarity=0, event data=0xA5 -> ttl_out=0xA5 one cycle later; event_count=1; last_event_ts=event timestamp.
REQ-037 mode=0x01, pulse_width=4, event data=0x01 at N -> ttl_out[0]=1 in cycles N+1..N+4, 0 at N+5; busy[0] mirrors this.
REQ-038 Same setup, second event data=0x01 at N+2 -> ttl_out[0] high through N+6; overlap_error=1 from N+3; err_clear pulse clears it.
REQ-039 polarity=0xFF, override_en=0x0F, override_val=0x05, level=0x00 -> ttl_out=0xFA.
REQ-040 pulse_width=0, event data=0x80 on pulse channel 7 -> single-cycle high; reset=0 mid-pulse (pulse_width=100) -> ttl_out=0, busy=0 next cycle.
REQ-041 Force event_count to 32'hFFFF_FFFE, then apply 3 events -> event_count holds at 32'hFFFF_FFFF.
